// File: rtl/auto_nav_scheduler.sv
// Autonomous navigation sequencer: settles on intersections, picks a direction
// by left-hand wall following, and drives the auto_turning trigger/ack handshake.
`timescale 1ns/1ps
module auto_nav_scheduler #(
  parameter int unsigned SETTLE_TIME = 5,
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned EXIT_TIME   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       front_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  input  logic       is_turning,
  output logic       trigger_turn_left,
  output logic       trigger_turn_right,
  output logic       trigger_turn_back,
  output logic       move_forward,
  output logic       fault,
  output logic [2:0] nav_state,
  output logic [7:0] turn_count
);
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TC_W  = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CRUISE   = 3'd1,
    DECIDE   = 3'd2,
    TRIG     = 3'd3,
    WAIT_ACK = 3'd4,
    TURNING  = 3'd5,
    EXIT     = 3'd6,
    FAULT    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_BACK  = 2'd2
  } dir_e;

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic [CNT_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0]   exit_cnt_q, exit_cnt_d;
  logic [TC_W-1:0]    turn_count_q, turn_count_d;
  logic               trig_left_q, trig_left_d;
  logic               trig_right_q, trig_right_d;
  logic               trig_back_q, trig_back_d;
  logic               move_q, move_d;
  logic               fault_q, fault_d;
  logic               intersection_c;

  assign intersection_c = !left_detector || front_detector;

  // Next-state, counters, and output decode from the next registered state
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    settle_cnt_d = '0;
    ack_cnt_d    = '0;
    exit_cnt_d   = '0;
    retry_cnt_d  = retry_cnt_q;
    turn_count_d = turn_count_q;

    case (state_q)
      IDLE: if (enable) state_d = CRUISE;
      CRUISE: begin
        if (intersection_c) begin
          if (settle_cnt_q == CNT_W'(SETTLE_TIME - 1)) state_d = DECIDE;
          else settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      DECIDE: begin
        retry_cnt_d = '0;
        if (!left_detector) begin
          dir_d   = DIR_LEFT;
          state_d = TRIG;
        end else if (!front_detector) begin
          state_d = EXIT;
        end else if (!right_detector) begin
          dir_d   = DIR_RIGHT;
          state_d = TRIG;
        end else begin
          dir_d   = DIR_BACK;
          state_d = TRIG;
        end
      end
      TRIG: state_d = WAIT_ACK;
      WAIT_ACK: begin
        // An acknowledge in the timeout cycle still counts
        if (is_turning) begin
          state_d = TURNING;
        end else if (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          if (retry_cnt_q < CNT_W'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + CNT_W'(1);
            state_d     = TRIG;
          end else begin
            state_d = FAULT;
          end
        end else begin
          ack_cnt_d = ack_cnt_q + CNT_W'(1);
        end
      end
      TURNING: begin
        if (!is_turning) begin
          turn_count_d = turn_count_q + TC_W'(1);
          state_d      = EXIT;
        end
      end
      EXIT: begin
        if (exit_cnt_q == CNT_W'(EXIT_TIME - 1)) state_d = CRUISE;
        else exit_cnt_d = exit_cnt_q + CNT_W'(1);
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    // Leaving autonomous mode overrides every other transition
    if (!enable) begin
      state_d      = IDLE;
      settle_cnt_d = '0;
      ack_cnt_d    = '0;
      retry_cnt_d  = '0;
      exit_cnt_d   = '0;
      turn_count_d = turn_count_q;
    end

    move_d       = (state_d == CRUISE) || (state_d == EXIT);
    trig_left_d  = (state_d == TRIG) && (dir_d == DIR_LEFT);
    trig_right_d = (state_d == TRIG) && (dir_d == DIR_RIGHT);
    trig_back_d  = (state_d == TRIG) && (dir_d == DIR_BACK);
    fault_d      = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= DIR_LEFT;
      settle_cnt_q <= '0;
      ack_cnt_q    <= '0;
      retry_cnt_q  <= '0;
      exit_cnt_q   <= '0;
      turn_count_q <= '0;
      trig_left_q  <= 1'b0;
      trig_right_q <= 1'b0;
      trig_back_q  <= 1'b0;
      move_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      settle_cnt_q <= settle_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      exit_cnt_q   <= exit_cnt_d;
      turn_count_q <= turn_count_d;
      trig_left_q  <= trig_left_d;
      trig_right_q <= trig_right_d;
      trig_back_q  <= trig_back_d;
      move_q       <= move_d;
      fault_q      <= fault_d;
    end
  end

  assign trigger_turn_left  = trig_left_q;
  assign trigger_turn_right = trig_right_q;
  assign trigger_turn_back  = trig_back_q;
  assign move_forward       = move_q;
  assign fault              = fault_q;
  assign nav_state          = state_q;
  assign turn_count         = turn_count_q;

endmodule

// File: tb/tb_auto_nav_scheduler.sv
// Bench for auto_nav_scheduler: scripted per-cycle timelines built from the
// navigation rules, with randomized detectors, ack latency and turn duration.
`timescale 1ns/1ps
module tb_auto_nav_scheduler;
  localparam int unsigned S = 5;
  localparam int unsigned A = 4;
  localparam int unsigned R = 3;
  localparam int unsigned E = 250;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CRUISE   = 3'd1;
  localparam logic [2:0] ST_DECIDE   = 3'd2;
  localparam logic [2:0] ST_TRIG     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;
  localparam logic [2:0] ST_TURNING  = 3'd5;
  localparam logic [2:0] ST_EXIT     = 3'd6;
  localparam logic [2:0] ST_FAULT    = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n, enable, is_turning;
  logic       front_detector, left_detector, right_detector;
  logic       trig_left, trig_right, trig_back, move_forward, fault;
  logic [2:0] nav_state;
  logic [7:0] turn_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_tc;
  int         exp_dir;   // 0 left, 1 right, 2 back, -1 straight through

  auto_nav_scheduler dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .front_detector     (front_detector),
    .left_detector      (left_detector),
    .right_detector     (right_detector),
    .is_turning         (is_turning),
    .trigger_turn_left  (trig_left),
    .trigger_turn_right (trig_right),
    .trigger_turn_back  (trig_back),
    .move_forward       (move_forward),
    .fault              (fault),
    .nav_state          (nav_state),
    .turn_count         (turn_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] act_vec();
    return {nav_state, move_forward, trig_left, trig_right, trig_back, fault, turn_count};
  endfunction

  // Expected outputs of a state given the bench's notion of direction and turn count
  function automatic logic [15:0] exp_vec(input logic [2:0] st);
    logic mv, l, r, b, f;
    mv = (st == ST_CRUISE) || (st == ST_EXIT);
    l  = (st == ST_TRIG) && (exp_dir == 0);
    r  = (st == ST_TRIG) && (exp_dir == 1);
    b  = (st == ST_TRIG) && (exp_dir == 2);
    f  = (st == ST_FAULT);
    return {st, mv, l, r, b, f, exp_tc};
  endfunction

  task automatic cyc(input logic [2:0] st, input string tag);
    @(negedge clk);
    check_eq(tag, act_vec(), exp_vec(st));
  endtask

  task automatic rand_dets();
    {left_detector, front_detector, right_detector} = 3'($urandom);
  endtask

  function automatic bit has_event(input logic [2:0] d);
    return !d[2] || d[1];
  endfunction

  // Short front glitch while cruising: must never reach DECIDE
  task automatic glitch(input int g);
    left_detector = 1'b1; front_detector = 1'b1; right_detector = 1'b1;
    for (int i = 0; i < g; i++) cyc(ST_CRUISE, "glitch");
    front_detector = 1'b0;
    repeat (S) cyc(ST_CRUISE, "glitch_drop");
  endtask

  // One intersection from CRUISE with a cleared settle count.
  // a = {L,F,R} while settling, b = {L,F,R} in the decide cycle.
  task automatic run_event(input logic [2:0] a, input logic [2:0] b, input int n_miss,
                           input int ack_idx, input int busy_len, input bit early,
                           input int abort);
    {left_detector, front_detector, right_detector} = a;
    for (int i = 0; i < int'(S) - 1; i++) cyc(ST_CRUISE, "settle");
    cyc(ST_DECIDE, "decide");
    {left_detector, front_detector, right_detector} = b;
    if (!b[2])      exp_dir = 0;
    else if (!b[1]) exp_dir = -1;
    else if (!b[0]) exp_dir = 1;
    else            exp_dir = 2;

    if (exp_dir == -1) begin
      for (int i = 0; i < int'(E); i++) begin
        cyc(ST_EXIT, "pass_exit");
        rand_dets();
      end
      cyc(ST_CRUISE, "pass_cruise");
      return;
    end

    for (int k = 0; k < n_miss; k++) begin
      cyc(ST_TRIG, "trig_retry");
      rand_dets();
      for (int j = 0; j < int'(A); j++) cyc(ST_WAIT_ACK, "wait_timeout");
    end
    if (n_miss > int'(R)) begin
      repeat (3) cyc(ST_FAULT, "fault");
      enable = 1'b0;
      cyc(ST_IDLE, "fault_clear");
      enable = 1'b1;
      cyc(ST_CRUISE, "fault_reenter");
      return;
    end

    cyc(ST_TRIG, "trig");
    rand_dets();
    if (early && ack_idx == 0) is_turning = 1'b1;
    for (int j = 0; j <= ack_idx; j++) begin
      cyc(ST_WAIT_ACK, "wait_ack");
      if (j == ack_idx) is_turning = 1'b1;
    end
    for (int t = 0; t < busy_len; t++) begin
      cyc(ST_TURNING, "turning");
      if (abort == 1) begin
        enable = 1'b0; is_turning = 1'b0;
        cyc(ST_IDLE, "abort_enable");
        enable = 1'b1;
        cyc(ST_CRUISE, "abort_reenter");
        return;
      end
      if (abort == 2) begin
        #2;
        rst_n = 1'b0; is_turning = 1'b0;
        #1;
        exp_tc = 8'd0;
        check_eq("abort_reset", act_vec(), exp_vec(ST_IDLE));
        cyc(ST_IDLE, "in_reset");
        rst_n = 1'b1;
        cyc(ST_CRUISE, "reset_reenter");
        return;
      end
      if (t == busy_len - 1) is_turning = 1'b0;
    end
    exp_tc = exp_tc + 8'd1;
    for (int i = 0; i < int'(E); i++) cyc(ST_EXIT, "turn_exit");
    cyc(ST_CRUISE, "turn_cruise");
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] a, b;
    rst_n = 1'b0; enable = 1'b0; is_turning = 1'b0;
    left_detector = 1'b0; front_detector = 1'b0; right_detector = 1'b0;
    exp_tc = 8'd0; exp_dir = 0;
    #1;
    check_eq("reset", act_vec(), exp_vec(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc(ST_IDLE, "idle_disabled");
    enable = 1'b1;
    cyc(ST_CRUISE, "enter_cruise");

    run_event(3'b001, 3'b001, 0, 0, 450, 1'b0, 0);   // left turn, long busy
    run_event(3'b111, 3'b111, 0, 1, 3, 1'b0, 0);     // dead end
    glitch(3);
    glitch(int'(S) - 1);
    run_event(3'b001, 3'b001, 0, 2, 2, 1'b0, 0);     // left after glitch
    run_event(3'b110, 3'b100, 0, 0, 1, 1'b0, 0);     // straight through
    run_event(3'b111, 3'b111, int'(R) + 1, 0, 1, 1'b0, 0); // no acknowledge
    run_event(3'b110, 3'b110, 0, int'(A) - 1, 4, 1'b0, 0); // late ack, right turn
    run_event(3'b011, 3'b011, 0, 0, 2, 1'b1, 0);     // ack already high at trigger
    run_event(3'b111, 3'b110, 2, 1, 3, 1'b0, 0);     // retries then ack
    run_event(3'b011, 3'b011, 0, 0, 5, 1'b0, 1);     // enable drop mid-turn
    run_event(3'b111, 3'b111, 0, 0, 5, 1'b0, 2);     // reset mid-turn

    for (int n = 0; n < 256; n++) begin
      do a = 3'($urandom); while (!has_event(a));
      b = 3'($urandom);
      if (b[2] && !b[1]) b[1] = 1'b1;
      run_event(a, b, 0, int'($urandom_range(0, A - 1)), 1, 1'b0, 0);
    end
    check_eq("wrap_turn_count", {8'h00, turn_count}, 16'h0000);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1) glitch(int'($urandom_range(1, S - 1)));
      do a = 3'($urandom); while (!has_event(a));
      b = 3'($urandom);
      run_event(a, b, int'($urandom_range(0, R + 1)), int'($urandom_range(0, A - 1)),
                int'($urandom_range(1, 20)), 1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/auto_nav_scheduler.md
# auto_nav_scheduler

Autonomous-mode navigation controller that sequences the `auto_turning` unit. It watches the car's obstacle detectors and moves forward while cruising. At an intersection it chooses a direction by a left-hand wall-following rule, fires one trigger pulse into `auto_turning`, and tracks that unit's `is_turning` handshake through completion. It then drives forward for a fixed exit interval before it evaluates the detectors again. It sits between the detector inputs and `auto_turning` / the forward-motion request in the autonomous driving path.

## Interface
- `SETTLE_TIME`, 5: consecutive cycles an intersection condition must hold before a decision is made.
- `ACK_TIMEOUT`, 4: cycles to wait for `is_turning` to rise after a trigger.
- `MAX_RETRY`, 3: number of re-triggers allowed before declaring a fault.
- `EXIT_TIME`, 250: forward-only cycles after a turn or pass-through (0.5 s at 500 Hz).
- `clk` input 1: 500 Hz system clock; all logic is on the posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: autonomous mode active.
- `front_detector`, `left_detector`, `right_detector` input 1 each: 1 = wall present on that side.
- `is_turning` input 1: busy flag from `auto_turning`.
- `trigger_turn_left`, `trigger_turn_right`, `trigger_turn_back` output 1 each: one-cycle request pulses to `auto_turning`; at most one is high in any cycle.
- `move_forward` output 1: forward-motion request.
- `fault` output 1: the turning unit never acknowledged a trigger.
- `nav_state` output 3: current state encoding, for debug.
- `turn_count` output 8: number of completed turns; wraps 255→0.

## Operation
- States and encodings:
  - IDLE = 0
  - CRUISE = 1
  - DECIDE = 2
  - TRIG = 3
  - WAIT_ACK = 4
  - TURNING = 5
  - EXIT = 6
  - FAULT = 7
- Intersection event = `!left_detector | front_detector`.
- IDLE: all outputs 0. If `enable` = 1, go to CRUISE.
- CRUISE: `move_forward` = 1.
  - The settle counter increments while the event holds and clears to 0 when it drops.
  - When the counter reaches `SETTLE_TIME-1` with the event still true, go to DECIDE.
- DECIDE: lasts one cycle, `move_forward` = 0. Direction is latched into `dir` and the retry counter is cleared, using this priority:
  1. Left open: go to TRIG with `dir` = LEFT.
  2. Else front open: go to EXIT (pass straight through, no turn).
  3. Else right open: go to TRIG with `dir` = RIGHT.
  4. Else: go to TRIG with `dir` = BACK.
- TRIG: lasts one cycle.
  - The trigger output selected by `dir` is 1.
  - The timeout counter clears.
  - Go to WAIT_ACK.
- WAIT_ACK: no outputs asserted.
  - If `is_turning` = 1, go to TURNING.
  - Else, when the timeout counter reaches `ACK_TIMEOUT-1`:
    - if retry count < `MAX_RETRY`, increment it and go to TRIG (the same `dir` is re-fired);
    - otherwise go to FAULT.
- TURNING: no outputs asserted. When `is_turning` = 0, increment `turn_count` and go to EXIT.
- EXIT: `move_forward` = 1 and detectors are ignored. The exit counter runs from 0 to `EXIT_TIME-1`, then the block goes to CRUISE with the settle counter at 0.
- FAULT: `fault` = 1 and all motion outputs are 0. The block stays here until `enable` = 0.
- `enable` = 0 in any state forces IDLE on the next edge and clears all counters except `turn_count`. This also drops any in-flight wait, because `auto_turning` aborts on its own `enable`.
- Outputs are decoded from the registered state and `dir`, with no input-to-output combinational path.
- Counters are 16-bit and saturate only via state exit; they never wrap in normal operation.

## Timing
- Reset:
  - state = IDLE;
  - `dir`, all counters and `turn_count` = 0;
  - all outputs 0;
  - `nav_state` = 0.
- Decision latency: an event that is first true at edge n and held gives DECIDE after edge n+`SETTLE_TIME`-1 and trigger high after edge n+`SETTLE_TIME`, i.e. `SETTLE_TIME`+1 cycles from onset to trigger.
- Each trigger pulse is exactly 1 `clk` period wide.
- Retries are spaced `ACK_TIMEOUT`+1 cycles apart (TRIG + `ACK_TIMEOUT` WAIT_ACK cycles).
- The fault path issues `MAX_RETRY`+1 triggers in total; `fault` rises on the edge after the last timeout.
- `is_turning` rising on the same cycle the timeout expires: acknowledge wins, go to TURNING.
- `is_turning` already high in the TRIG cycle: it is sampled in WAIT_ACK on the next cycle and accepted.
- `turn_count` updates on the TURNING→EXIT edge. Pass-through (DECIDE→EXIT) does not count.
- EXIT lasts exactly `EXIT_TIME` cycles with `move_forward` = 1.
- `enable` dropping in the same cycle as any transition condition: IDLE wins.
- `rst_n` asserted mid-turn: immediate asynchronous return to reset values.

## Test plan
- **Left turn.** Reset, then `enable` = 1 with left = 0, front = 0, right = 1 held.
  - After 5 CRUISE cycles there is 1 DECIDE cycle, then `trigger_turn_left` pulses for 1 cycle.
  - Model `is_turning` high for 450 cycles.
  - Expect `turn_count` = 1, then 250 cycles with `move_forward` = 1, then CRUISE.
- **Dead end.** left = front = right = 1: a single `trigger_turn_back` pulse; no other trigger ever asserted.
- **Pass-through.** left = 1, right = 1, front 0→1 glitch for 3 cycles then 0.
  - No DECIDE: the settle counter resets.
  - Then hold front = 0 with left = 0 → a left turn.
  - Hold left = 1, front = 0, right = 0 after a 5-cycle event (using a front = 1 glitch) → DECIDE→EXIT, no trigger, `turn_count` unchanged.
- **No acknowledge.** `is_turning` held 0.
  - Expect 4 trigger pulses 5 cycles apart, then `fault` = 1 and `nav_state` = 7.
  - `enable` = 0 → IDLE and `fault` = 0.
- **Late acknowledge.** `is_turning` rises exactly on the 4th WAIT_ACK cycle → TURNING, no retry pulse.
- **Abort.** `rst_n` pulse or `enable` = 0 during TURNING → all outputs 0 at once (reset) or on the next edge (`enable`).
  - Wrap check: 256 completed turns → `turn_count` = 0.
